// File: rtl/obm_dma.sv
// obm_dma: copies LENGTH bytes from CPU work RAM (page src_page) into GPU
// VRAM starting at DST_BASE. A VRAM write happens only while the video
// timing window `writable` is high, so one transfer may span several vblanks.
//
// Ports:
//   clk, rst            pixel clock, asynchronous active-low reset
//   start, abort        begin a transfer (from IDLE) / cancel the transfer
//   src_page            source page, latched on start
//   busy, done          transfer in progress / one-cycle completion pulse
//   src_addr, src_req   work RAM read request, held until src_ack
//   src_ack, src_data   read acknowledge with same-cycle data
//   writable            VRAM write window
//   vram_address, vram_data, vram_write_enable   VRAM write port
module obm_dma #(
   parameter int          LENGTH   = 256,
   parameter logic [11:0] DST_BASE = 12'h800
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [7:0]  src_page,
   output logic        busy,
   output logic        done,
   output logic [15:0] src_addr,
   output logic        src_req,
   input  logic        src_ack,
   input  logic [7:0]  src_data,
   input  logic        writable,
   output logic [11:0] vram_address,
   output logic [7:0]  vram_data,
   output logic        vram_write_enable
);

   typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

   localparam logic [8:0] LAST = 9'(LENGTH - 1);

   state_t      state_reg;
   logic [8:0]  count_reg;
   logic [7:0]  page_reg;
   logic [7:0]  buffer_reg;
   logic [11:0] address_reg;
   logic        done_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         count_reg   <= 9'd0;
         page_reg    <= 8'd0;
         buffer_reg  <= 8'd0;
         address_reg <= DST_BASE;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  page_reg  <= src_page;
                  count_reg <= 9'd0;
                  state_reg <= FETCH;
               end
            end
            FETCH: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (src_ack) begin
                  // The write address is captured together with the byte so
                  // that both hold steady in WRITE and after the transfer.
                  buffer_reg  <= src_data;
                  address_reg <= DST_BASE + {4'h0, count_reg[7:0]};
                  state_reg   <= WRITE;
               end
            end
            WRITE: begin
               if (abort) begin
                  state_reg <= IDLE;
               end else if (writable) begin
                  if (count_reg == LAST) begin
                     state_reg <= IDLE;
                     done_reg  <= 1'b1;
                  end else begin
                     count_reg <= count_reg + 9'd1;
                     state_reg <= FETCH;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // Decoded from registered state only, so reset removes them at once and
   // the VRAM sink sees the strobe in the same cycle as the commit edge.
   assign busy              = (state_reg != IDLE);
   assign src_req           = (state_reg == FETCH);
   assign src_addr          = {page_reg, count_reg[7:0]};
   assign vram_write_enable = (state_reg == WRITE) && writable;
   assign vram_address      = address_reg;
   assign vram_data         = buffer_reg;
   assign done              = done_reg;

endmodule

// File: tb/tb_obm_dma.sv
// tb_obm_dma: drives obm_dma (LENGTH=256) from a work RAM model with random
// ack latency and records every VRAM strobe; a second LENGTH=1 instance
// covers the single-byte case and back-to-back starts.
module tb_obm_dma;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  src_page = 8'd0;
   logic        busy, done, src_req, vram_write_enable;
   logic [15:0] src_addr;
   logic        src_ack = 1'b0;
   logic [7:0]  src_data = 8'd0;
   logic        writable = 1'b1;
   logic [11:0] vram_address;
   logic [7:0]  vram_data;

   logic        o_start = 1'b0;
   logic        o_busy, o_done, o_src_req, o_vram_write_enable;
   logic [15:0] o_src_addr;
   logic [11:0] o_vram_address;
   logic [7:0]  o_vram_data;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   obm_dma #(.LENGTH(256), .DST_BASE(12'h800)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .src_page(src_page),
      .busy(busy), .done(done), .src_addr(src_addr), .src_req(src_req),
      .src_ack(src_ack), .src_data(src_data), .writable(writable),
      .vram_address(vram_address), .vram_data(vram_data),
      .vram_write_enable(vram_write_enable)
   );

   obm_dma #(.LENGTH(1), .DST_BASE(12'h800)) u_one (
      .clk(clk), .rst(rst), .start(o_start), .abort(1'b0), .src_page(8'h11),
      .busy(o_busy), .done(o_done), .src_addr(o_src_addr), .src_req(o_src_req),
      .src_ack(1'b1), .src_data(8'h3C), .writable(1'b1),
      .vram_address(o_vram_address), .vram_data(o_vram_data),
      .vram_write_enable(o_vram_write_enable)
   );

   // ---------------- work RAM model and source responder ----------------
   logic [7:0] ram [0:65535];
   int  max_delay = 0;
   int  total_delay = 0;
   int  wait_cnt = 0;
   bit  active = 1'b0;

   always @(negedge clk) begin
      if (!src_req) begin
         src_ack = 1'b0;
         active  = 1'b0;
      end else begin
         if (!active) begin
            active      = 1'b1;
            wait_cnt    = $urandom_range(max_delay, 0);
            total_delay = total_delay + wait_cnt;
         end
         if (wait_cnt == 0) begin
            src_ack  = 1'b1;
            src_data = ram[src_addr];
         end else begin
            src_ack  = 1'b0;
            wait_cnt = wait_cnt - 1;
         end
      end
   end

   // ---------------- VRAM sink / activity log ----------------
   logic [11:0] wr_addr_q [$];
   logic [7:0]  wr_data_q [$];
   logic [7:0]  obm [0:255];
   int          cycle = 0;
   int          done_cnt = 0;
   int          done_cycle = 0;
   int          busy_rise_cycle = 0;
   int          unstable = 0;
   logic        prev_busy = 1'b0;
   logic        prev_req = 1'b0;
   logic [15:0] prev_addr = 16'd0;

   always @(negedge clk) begin
      #2;
      cycle = cycle + 1;
      if (vram_write_enable) begin
         wr_addr_q.push_back(vram_address);
         wr_data_q.push_back(vram_data);
         obm[vram_address[7:0]] = vram_data;
      end
      if (done) begin
         done_cnt   = done_cnt + 1;
         done_cycle = cycle;
      end
      if (busy && !prev_busy) busy_rise_cycle = cycle;
      if (src_req && prev_req && src_addr != prev_addr) unstable = unstable + 1;
      prev_busy = busy;
      prev_req  = src_req;
      prev_addr = src_addr;
   end

   // Expected image: byte i of the page lands at 0x800+i.
   function automatic int bad_writes(input logic [7:0] page, input int n);
      int bad = 0;
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
         logic [7:0] idx = 8'(i);
         if (wr_addr_q[i] != 12'h800 + 12'(i) || wr_data_q[i] != ram[{page, idx}])
            bad++;
      end
      return bad;
   endfunction

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      done_cnt    = 0;
      unstable    = 0;
      total_delay = 0;
      for (int i = 0; i < 256; i++) obm[i] = 8'hxx;
   endtask

   task automatic launch(input logic [7:0] page);
      @(negedge clk);
      src_page = page;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit timeout);
      int d0 = done_cnt;
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #3;
         if (done_cnt > d0) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   // Waits (at negedge+1) for the FETCH of a given byte index.
   task automatic wait_fetch(input int idx, input int budget, output bit timeout);
      timeout = 1'b1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (src_req && src_addr[7:0] == 8'(idx)) begin
            timeout = 1'b0;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      #3;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || src_req !== 1'b0 || vram_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b src_req=%b we=%b, required all 0",
                  busy, done, src_req, vram_write_enable);
      end
      checks++;
      if (src_addr !== 16'h0000 || vram_address !== 12'h800 || vram_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: src_addr=%h vram_address=%h vram_data=%h, required 0000/800/00",
                  src_addr, vram_address, vram_data);
      end
      @(negedge clk);
      rst = 1'b1;
      $display("reset: released");
   endtask

   task automatic test_basic();
      bit to;
      int mism = 0;
      clear_log();
      launch(8'h02);
      wait_done(800, to);
      checks++;
      if (to) begin errors++; $display("FAIL basic_timeout: done not seen within 800 cycles"); end
      checks++;
      if (wr_addr_q.size() != 256) begin
         errors++; $display("FAIL basic_strobes: got %0d, required 256", wr_addr_q.size());
      end
      checks++;
      if (bad_writes(8'h02, 256) != 0) begin
         errors++; $display("FAIL basic_data: %0d bad writes, required 0", bad_writes(8'h02, 256));
      end
      checks++;
      if (done_cycle - busy_rise_cycle != 512) begin
         errors++; $display("FAIL basic_cycles: got %0d, required 512", done_cycle - busy_rise_cycle);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_in_done: busy=%b, required 0", busy); end
      for (int i = 0; i < 256; i++) if (obm[i] !== ram[16'h0200 + 16'(i)]) mism++;
      checks++;
      if (mism != 0) begin errors++; $display("FAIL basic_obm: %0d bytes differ, required 0", mism); end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL basic_done_pulse: %0d done cycles, required 1", done_cnt); end
      $display("basic: strobes=%0d cycles=%0d", wr_addr_q.size(), done_cycle - busy_rise_cycle);
   endtask

   task automatic test_writable_gating();
      bit to;
      int n0, hold_bad = 0, hits = 0;
      clear_log();
      launch(8'h02);
      wait_fetch(10, 100, to);
      checks++;
      if (to) begin errors++; $display("FAIL gate_reach: byte 10 fetch not seen"); end
      writable = 1'b0;
      n0 = wr_addr_q.size();
      repeat (99) begin
         @(negedge clk);
         #3;
         if (!src_req && (vram_address !== 12'h80A || vram_data !== ram[16'h020A])) hold_bad++;
      end
      checks++;
      if (wr_addr_q.size() != n0) begin
         errors++; $display("FAIL gate_no_strobe: %0d strobes during gap, required 0", wr_addr_q.size() - n0);
      end
      checks++;
      if (hold_bad != 0) begin errors++; $display("FAIL gate_hold: %0d cycles changed, required 0", hold_bad); end
      @(negedge clk);
      writable = 1'b1;
      wait_done(800, to);
      for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] == 12'h80A) hits++;
      checks++;
      if (to || wr_addr_q.size() != 256 || hits != 1 || bad_writes(8'h02, 256) != 0) begin
         errors++;
         $display("FAIL gate_total: timeout=%0d strobes=%0d hits_80A=%0d, required 0/256/1", to, wr_addr_q.size(), hits);
      end
      $display("writable_gating: strobes=%0d hits_80A=%0d", wr_addr_q.size(), hits);
   endtask

   task automatic test_ack_latency();
      bit to;
      clear_log();
      max_delay = 3;
      launch(8'h03);
      wait_done(2500, to);
      max_delay = 0;
      checks++;
      if (to) begin errors++; $display("FAIL lat_timeout: done not seen"); end
      checks++;
      if (unstable != 0) begin errors++; $display("FAIL lat_addr_stable: %0d changes, required 0", unstable); end
      checks++;
      if (wr_addr_q.size() != 256 || bad_writes(8'h03, 256) != 0) begin
         errors++; $display("FAIL lat_data: strobes=%0d bad=%0d, required 256/0", wr_addr_q.size(), bad_writes(8'h03, 256));
      end
      checks++;
      if (done_cycle - busy_rise_cycle != 512 + total_delay) begin
         errors++;
         $display("FAIL lat_cycles: got %0d, required %0d", done_cycle - busy_rise_cycle, 512 + total_delay);
      end
      $display("ack_latency: delay=%0d cycles=%0d", total_delay, done_cycle - busy_rise_cycle);
   endtask

   task automatic test_start_while_busy();
      bit to;
      clear_log();
      launch(8'h02);
      wait_fetch(50, 200, to);
      src_page = 8'h05;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      wait_done(800, to);
      repeat (10) @(negedge clk);
      #3;
      checks++;
      if (to || bad_writes(8'h02, 256) != 0 || wr_addr_q.size() != 256) begin
         errors++; $display("FAIL busy_start_data: timeout=%0d strobes=%0d, required page 02 image", to, wr_addr_q.size());
      end
      checks++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         errors++; $display("FAIL busy_start_done: done=%0d busy=%b, required 1/0", done_cnt, busy);
      end
      $display("start_while_busy: strobes=%0d done=%0d", wr_addr_q.size(), done_cnt);
   endtask

   task automatic test_abort();
      bit to = 1'b1;
      clear_log();
      launch(8'h02);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (vram_write_enable && vram_address == 12'h863) begin to = 1'b0; break; end
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #3;
      checks++;
      if (to || busy !== 1'b0) begin errors++; $display("FAIL abort_busy: timeout=%0d busy=%b, required 0/0", to, busy); end
      repeat (10) @(negedge clk);
      checks++;
      if (done_cnt != 0) begin errors++; $display("FAIL abort_done: %0d, required 0", done_cnt); end
      checks++;
      if (wr_addr_q.size() != 100 || bad_writes(8'h02, 100) != 0) begin
         errors++; $display("FAIL abort_strobes: %0d, required 100 at 800..863", wr_addr_q.size());
      end
      $display("abort: strobes=%0d", wr_addr_q.size());
      clear_log();
      launch(8'h02);
      wait_done(800, to);
      checks++;
      if (to || wr_addr_q.size() == 0 || wr_addr_q[0] !== 12'h800 || bad_writes(8'h02, 256) != 0) begin
         errors++; $display("FAIL abort_restart: timeout=%0d strobes=%0d, required restart at 800", to, wr_addr_q.size());
      end
      $display("abort_restart: strobes=%0d", wr_addr_q.size());
   endtask

   task automatic test_async_reset();
      bit to = 1'b1;
      clear_log();
      launch(8'h02);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (vram_write_enable && vram_address == 12'h805) begin to = 1'b0; break; end
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (to || vram_write_enable !== 1'b0 || src_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL async_ctrl: timeout=%0d we=%b req=%b busy=%b done=%b, required all 0",
                  to, vram_write_enable, src_req, busy, done);
      end
      checks++;
      if (src_addr !== 16'h0000 || vram_address !== 12'h800 || vram_data !== 8'h00) begin
         errors++;
         $display("FAIL async_data: src_addr=%h vram_address=%h vram_data=%h, required 0000/800/00",
                  src_addr, vram_address, vram_data);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      #3;
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL async_after: done=%0d busy=%b, required 0/0", done_cnt, busy);
      end
      $display("async_reset: strobes_before=%0d", wr_addr_q.size());
   endtask

   task automatic test_length_one();
      int strobes = 0, dones = 0, busy_at = -1, done_at = -1;
      logic busy_in_done = 1'b1;
      logic [11:0] a = 12'h000;
      logic [7:0]  d = 8'h00;
      @(negedge clk);
      o_start = 1'b1;
      @(negedge clk);
      o_start = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         #3;
         if (o_busy && busy_at < 0) busy_at = i;
         if (o_vram_write_enable) begin strobes++; a = o_vram_address; d = o_vram_data; end
         if (o_done) begin dones++; if (done_at < 0) begin done_at = i; busy_in_done = o_busy; end end
         @(negedge clk);
      end
      checks++;
      if (strobes != 1 || a !== 12'h800 || d !== 8'h3C) begin
         errors++; $display("FAIL one_strobe: count=%0d addr=%h data=%h, required 1/800/3c", strobes, a, d);
      end
      checks++;
      if (busy_at != 1 || done_at != 3 || dones != 1 || busy_in_done !== 1'b0) begin
         errors++;
         $display("FAIL one_timing: busy_at=%0d done_at=%0d dones=%0d busy_in_done=%b, required 1/3/1/0",
                  busy_at, done_at, dones, busy_in_done);
      end
      $display("length_one: strobes=%0d done_at=%0d", strobes, done_at);
   endtask

   task automatic test_back_to_back();
      bit to = 1'b1;
      int strobes = 0;
      @(negedge clk);
      o_start = 1'b1;
      @(negedge clk);
      o_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #3;
         if (o_done) begin to = 1'b0; break; end
         @(negedge clk);
      end
      o_start = 1'b1;
      @(negedge clk);
      o_start = 1'b0;
      #3;
      checks++;
      if (to || o_busy !== 1'b1 || o_src_req !== 1'b1) begin
         errors++; $display("FAIL b2b_accept: timeout=%0d busy=%b req=%b, required 0/1/1", to, o_busy, o_src_req);
      end
      for (int i = 0; i < 4; i++) begin
         if (o_vram_write_enable) strobes++;
         @(negedge clk);
         #3;
      end
      checks++;
      if (strobes != 1 || o_busy !== 1'b0) begin
         errors++; $display("FAIL b2b_second: strobes=%0d busy=%b, required 1/0", strobes, o_busy);
      end
      $display("back_to_back: second strobes=%0d", strobes);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
      for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
      for (int i = 0; i < 256; i++) ram[16'h0500 + 16'(i)] = 8'(i) ^ 8'h5A;
      test_reset();
      test_basic();
      test_writable_gating();
      test_ack_latency();
      test_start_while_busy();
      test_abort();
      test_async_reset();
      test_length_one();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/obm_dma.md
# obm_dma

DMA engine that copies a block of bytes from CPU work RAM into GPU VRAM through the VRAM write port (address / data / write_enable). It is the writing end of the VRAM interface: it drives the port that the foreground and background units sample, and issues a write only in cycles where the video timing `writable` is high. Its default use is the once-per-frame copy of a 256-byte object table into Object Memory (VRAM 0x800–0x8FF) during vblank.

## Interface
- `LENGTH`, 256: bytes per transfer; legal range 1..256.
- `DST_BASE`, 12'h800: first VRAM destination address.

- `clk`  in  1  GPU pixel clock (12.5875 MHz)
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle request to begin a transfer
- `abort`  in  1  cancel the transfer in progress
- `src_page`  in  8  source page; source base = {src_page, 8'h00}
- `busy`  out  1  high from the cycle after accepted `start` until the transfer ends
- `done`  out  1  one-cycle pulse after the last byte is written
- `src_addr`  out  16  work RAM read address
- `src_req`  out  1  read request
- `src_ack`  in  1  read acknowledge; `src_data` valid in the same cycle
- `src_data`  in  8  read data
- `writable`  in  1  video timing write window
- `vram_address`  out  12  VRAM write address
- `vram_data`  out  8  VRAM write data
- `vram_write_enable`  out  1  VRAM write strobe

## Operation
- States: IDLE, FETCH, WRITE.
- IDLE: `start` high at a clock edge latches `src_page`, clears the 9-bit `count` to 0, and enters FETCH. `start` is ignored in FETCH and WRITE.
- FETCH: `src_req`=1 and `src_addr`={page, count[7:0]}, both held stable until `src_ack`. On an edge with `src_ack`=1, `src_data` is captured into the byte buffer and the state moves to WRITE.
- WRITE: `vram_address`=DST_BASE+count[7:0], truncated to 12 bits. `vram_data` is the byte buffer. `vram_write_enable`=writable, combinational from registered state, so the sink samples it on the same edge.
  - Edge with `writable`=1: byte committed. If count==LENGTH-1, go to IDLE and pulse `done`. Otherwise count++ and go to FETCH.
  - Edge with `writable`=0: stay in WRITE and hold address and data. A transfer can span several vblanks.
- `abort` high at an edge in FETCH or WRITE goes to IDLE with no `done` pulse. Bytes already written stay written. An outstanding `src_req` is dropped; the source must tolerate a withdrawn request. `abort` has priority over a coincident `src_ack` or write commit. `abort` in IDLE has no effect.
- `busy` = (state != IDLE).
- Outputs outside WRITE: `vram_write_enable`=0. `vram_address` and `vram_data` hold their last values.
- Outputs outside FETCH: `src_req`=0.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE, count 0, page 0, buffer 0
  - `busy`=0, `done`=0, `src_req`=0, `src_addr`=0
  - `vram_write_enable`=0, `vram_address`=DST_BASE, `vram_data`=0
- Reset asserted mid-transfer aborts it immediately, with no `done` pulse.
- `start` sampled at edge N: `busy` and `src_req` are high in cycle N+1.
- Per byte, minimum 2 cycles: one FETCH cycle with immediate ack, then one WRITE cycle with `writable`=1.
- Each cycle of `src_ack` delay or `writable`=0 adds one cycle.
- With immediate ack and constant `writable`, LENGTH=256 takes 512 cycles. `done` is high in the cycle after the final commit edge, and `busy` is low in that same cycle.
- `done` is high for exactly one cycle. A new `start` is accepted in the `done` cycle.
- Exactly LENGTH write strobes per uninterrupted transfer. Addresses are strictly ascending DST_BASE..DST_BASE+LENGTH-1, with no duplicates.

## Test plan
- Basic copy:
  - Stimulus: RAM page 0x02 filled with byte i = i^0xA5; immediate ack; `writable`=1; `start`.
  - Required: 256 strobes at 0x800..0x8FF with matching data; `done` 512 cycles after `busy` rises; foreground OBM model equals the source.
- Writable gating:
  - Stimulus: `writable` low for 100 cycles starting at byte 10.
  - Required: no strobe during the gap; address 0x80A and its data held; byte 10 written once when `writable` returns; total 256 strobes.
- Ack latency:
  - Stimulus: `src_ack` delayed by 0–3 random cycles per byte.
  - Required: `src_addr` stable while `src_req` is high; data correct; cycle count = 512 + total delay.
- Start while busy:
  - Stimulus: `start` pulsed at byte 50 with a different `src_page`.
  - Required: ignored; source page unchanged; one `done`.
- Abort:
  - Stimulus: `abort` at the byte 100 commit edge.
  - Required: `busy` low next cycle; no `done`; exactly 100 strobes (0x800..0x863).
  - Follow-up: a fresh `start` restarts from 0x800.
- Async reset:
  - Stimulus: `rst` low mid-WRITE, between clock edges.
  - Required: `vram_write_enable`, `src_req`, and `busy` drop without waiting for a clock edge; all outputs at reset values; no `done`.
- LENGTH=1 variant:
  - Required: single strobe at DST_BASE; `done` 2 cycles after `start`.
